flag_status_unit: RTL and testbench

- Consumer side of the datapath zero-detect path: registers the ALU condition flags and resolves branch conditions against them for the control unit.
- Z is computed internally from the ALU result. N, C and V are latched alongside it. The unit also keeps a small save/restore stack of flags for interrupt entry and exit.
- Sits between the ALU output and the controller's branch/next-PC logic.

---
 rtl/flag_status_if.sv | 29 ++
 rtl/flag_status_unit.sv | 99 +++++++++
 tb/tb_flag_status_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/flag_status_if.sv
// Bus between the ALU/controller side and the flag status unit.
// The master drives the ALU outputs, branch requests and stack commands; the slave returns flags and branch results.
interface flag_status_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             flag_we;
  logic             br_valid;
  logic [2:0]       cond;
  logic             br_ready;
  logic             br_done;
  logic             br_taken;
  logic             save;
  logic             restore;
  logic [3:0]       flags;
  logic             stk_empty;
  logic             stk_full;
  logic             err;

  modport master (
    output alu_res, alu_c, alu_v, flag_we, br_valid, cond, save, restore,
    input  br_ready, br_done, br_taken, flags, stk_empty, stk_full, err
  );

  modport slave (
    input  alu_res, alu_c, alu_v, flag_we, br_valid, cond, save, restore,
    output br_ready, br_done, br_taken, flags, stk_empty, stk_full, err
  );
endinterface

// File: rtl/flag_status_unit.sv
// Registers ALU condition flags {N,Z,C,V}, resolves branch conditions against them
// (forwarding a same-cycle flag write), and keeps a small LIFO of saved flags.
module flag_status_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  flag_status_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    flags_q, flags_d;
  logic          br_done_q, br_done_d;
  logic          br_taken_q, br_taken_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    stk_q [DEPTH];
  logic [3:0]    stk_d [DEPTH];

  logic [3:0] alu_flags, eval_flags, top;
  logic       full, empty, do_push, do_pop, misuse, accept, cond_hit;

  // Handshake: a request transfers on a rising edge where br_valid & br_ready;
  // the requester holds br_valid/cond until then. br_done pulses the cycle after
  // transfer with br_taken, which holds until the next br_done.
  always_comb begin
    alu_flags = {bus.alu_res[WIDTH-1], bus.alu_res == '0, bus.alu_c, bus.alu_v};
    full      = (cnt_q == CW'(DEPTH));
    empty     = (cnt_q == '0);
    do_push   = bus.save & ~bus.restore & ~full;
    do_pop    = bus.restore & ~bus.save & ~empty;
    misuse    = (bus.save & bus.restore) | (bus.save & full) | (bus.restore & empty);

    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = stk_q[i];
    end

    // The stack captures the registered flags, never the value being written.
    stk_d = stk_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && cnt_q == CW'(i)) stk_d[i] = flags_q;
    end

    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);

    // A real pop wins over flag_we; a refused restore lets the write through.
    flags_d = flags_q;
    if (do_pop)           flags_d = top;
    else if (bus.flag_we) flags_d = alu_flags;

    err_d = err_q | misuse;

    // Popped flags are not forwarded, so requests stall during any restore.
    accept     = bus.br_valid & ~bus.restore;
    eval_flags = bus.flag_we ? alu_flags : flags_q;
    case (bus.cond)
      3'b000:  cond_hit = 1'b1;
      3'b001:  cond_hit = eval_flags[2];
      3'b010:  cond_hit = ~eval_flags[2];
      3'b011:  cond_hit = eval_flags[1];
      3'b100:  cond_hit = ~eval_flags[1];
      3'b101:  cond_hit = eval_flags[3];
      3'b110:  cond_hit = eval_flags[0];
      default: cond_hit = 1'b0;
    endcase
    br_done_d  = accept;
    br_taken_d = accept ? cond_hit : br_taken_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      flags_q    <= flags_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      stk_q      <= stk_d;
    end
  end

  assign bus.br_ready  = ~bus.restore;
  assign bus.br_done   = br_done_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.flags     = flags_q;
  assign bus.stk_empty = (cnt_q == '0);
  assign bus.stk_full  = (cnt_q == CW'(DEPTH));
  assign bus.err       = err_q;
endmodule

// File: tb/tb_flag_status_unit.sv
// Directed bench for flag_status_unit: a vector table applied cycle by cycle,
// then hand sequences for restore priority and asynchronous reset mid-stream.
module tb_flag_status_unit;
  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  flag_status_if #(.WIDTH(8)) bus ();

  flag_status_unit #(.WIDTH(8), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       c, v, we, bv;
    logic [2:0] cond;
    logic       sv, rs;
    logic [3:0] e_flags;
    logic       e_done, e_taken, e_empty, e_full, e_err, e_ready;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic [7:0] res, input logic c, input logic v,
                              input logic we, input logic bv, input logic [2:0] cond,
                              input logic sv, input logic rs, input logic [3:0] ef,
                              input logic ed, input logic et, input logic ee,
                              input logic efu, input logic eer, input logic erd);
    vec_t r;
    r.res = res; r.c = c; r.v = v; r.we = we; r.bv = bv; r.cond = cond;
    r.sv = sv; r.rs = rs; r.e_flags = ef; r.e_done = ed; r.e_taken = et;
    r.e_empty = ee; r.e_full = efu; r.e_err = eer; r.e_ready = erd;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] res, input logic c, input logic v, input logic we,
                       input logic bv, input logic [2:0] cond, input logic sv, input logic rs);
    bus.alu_res = res; bus.alu_c = c; bus.alu_v = v; bus.flag_we = we;
    bus.br_valid = bv; bus.cond = cond; bus.save = sv; bus.restore = rs;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    idle();

    //         res    c     v     we    bv    cond    sv    rs    flags    done  taken empty full  err   ready
    vecs[0]  = mk(8'h00,1'b1,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,4'b0110,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[1]  = mk(8'h80,1'b0,1'b1,1'b1,1'b0,3'b000,1'b0,1'b0,4'b1001,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[2]  = mk(8'h01,1'b0,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[3]  = mk(8'h00,1'b0,1'b0,1'b1,1'b1,3'b001,1'b0,1'b0,4'b0100,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1);
    vecs[4]  = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b010,1'b0,1'b0,4'b0100,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[5]  = mk(8'h01,1'b1,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,4'b0010,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[6]  = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,4'b0010,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1);
    vecs[7]  = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b111,1'b0,1'b0,4'b0010,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1);
    vecs[8]  = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b011,1'b0,1'b0,4'b0010,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1);
    vecs[9]  = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,4'b0010,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1);
    vecs[10] = mk(8'h00,1'b0,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,4'b0100,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1);
    vecs[11] = mk(8'h01,1'b1,1'b0,1'b1,1'b0,3'b000,1'b1,1'b0,4'b0010,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1);
    vecs[12] = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b1,1'b0,4'b0010,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1);
    vecs[13] = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b1,1'b0,4'b0010,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1);
    vecs[14] = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b1,4'b0010,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0);
    vecs[15] = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b1,4'b0100,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0);
    vecs[16] = mk(8'h00,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b1,4'b0100,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0);
    vecs[17] = mk(8'h80,1'b0,1'b0,1'b1,1'b0,3'b000,1'b0,1'b1,4'b1000,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0);
    vecs[18] = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b101,1'b0,1'b0,4'b1000,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1);
    vecs[19] = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b110,1'b0,1'b0,4'b1000,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1);
    vecs[20] = mk(8'h00,1'b0,1'b0,1'b0,1'b1,3'b100,1'b0,1'b0,4'b1000,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1);
    vecs[21] = mk(8'h00,1'b1,1'b1,1'b1,1'b0,3'b000,1'b1,1'b1,4'b0111,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0);

    // Reset state.
    #12;
    chk4("reset flags", bus.flags, 4'b0000);
    chk1("reset br_done", bus.br_done, 1'b0);
    chk1("reset br_taken", bus.br_taken, 1'b0);
    chk1("reset br_ready", bus.br_ready, 1'b1);
    chk1("reset err", bus.err, 1'b0);
    chk1("reset stk_empty", bus.stk_empty, 1'b1);
    chk1("reset stk_full", bus.stk_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].we, vecs[i].bv,
            vecs[i].cond, vecs[i].sv, vecs[i].rs);
      #1;
      chk1($sformatf("v%0d br_ready", i), bus.br_ready, vecs[i].e_ready);
      step();
      chk4($sformatf("v%0d flags", i), bus.flags, vecs[i].e_flags);
      chk1($sformatf("v%0d br_done", i), bus.br_done, vecs[i].e_done);
      chk1($sformatf("v%0d br_taken", i), bus.br_taken, vecs[i].e_taken);
      chk1($sformatf("v%0d stk_empty", i), bus.stk_empty, vecs[i].e_empty);
      chk1($sformatf("v%0d stk_full", i), bus.stk_full, vecs[i].e_full);
      chk1($sformatf("v%0d err", i), bus.err, vecs[i].e_err);
    end

    // Restore priority over flag_we and a stalled branch request.
    do_reset();
    drive(8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0); step();
    drive(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0); step();
    chk4("prio pre flags", bus.flags, 4'b0010);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1);
    #1;
    chk1("prio br_ready low", bus.br_ready, 1'b0);
    step();
    chk4("prio popped flags", bus.flags, 4'b1000);
    chk1("prio no done", bus.br_done, 1'b0);
    chk1("prio stk_empty", bus.stk_empty, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    #1;
    chk1("prio br_ready high", bus.br_ready, 1'b1);
    step();
    chk1("prio late done", bus.br_done, 1'b1);
    chk1("prio late taken", bus.br_taken, 1'b0);
    chk1("prio err", bus.err, 1'b0);
    idle(); step();
    chk1("prio done drops", bus.br_done, 1'b0);

    // Asynchronous reset with br_done high, two entries stacked and err set.
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0); step();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0); step();
    chk1("midrst pre done", bus.br_done, 1'b1);
    chk1("midrst pre full", bus.stk_full, 1'b1);
    chk1("midrst pre err", bus.err, 1'b1);
    chk4("midrst pre flags", bus.flags, 4'b0100);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk4("midrst flags", bus.flags, 4'b0000);
    chk1("midrst br_done", bus.br_done, 1'b0);
    chk1("midrst br_taken", bus.br_taken, 1'b0);
    chk1("midrst stk_empty", bus.stk_empty, 1'b1);
    chk1("midrst stk_full", bus.stk_full, 1'b0);
    chk1("midrst err", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Stack was discarded: a restore now is a misuse and leaves flags alone.
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1); step();
    chk4("post rst restore flags", bus.flags, 4'b0000);
    chk1("post rst restore err", bus.err, 1'b1);
    idle(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
